reaction_game_core: RTL
=======================

REACTION_GAME_CORE -- requirements
Module: reaction_game_core

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of hit buttons (1..8).
REQ-002 SHALL have parameter SCORE_W, default 13, score/counter width in ms ticks.
REQ-003 SHALL have parameter HIST_DEPTH, default 8, stored results (power of 2, 2..16).
REQ-004 SHALL have parameter TICK_DIV, default 50000, Clock cycles per 1 ms tick.
REQ-005 SHALL have port Clock  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port CLRN  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port buttonStart  input  1  start request, level, synchronous to Clock.
REQ-008 SHALL have port buttonHit  input  NUM_PLAYERS  per-player hit buttons, level, synchronous.
REQ-009 SHALL have port GreenLed  output  1  high in GO.
REQ-010 SHALL have port RedLed  output  1  high in FOUL.
REQ-011 SHALL have port state  output  3  encoded FSM state.
REQ-012 SHALL have port winner  output  3  index of the player who hit first or fouled.
REQ-013 SHALL have port winnerValid  output  1  winner field meaningful.
REQ-014 SHALL have port score  output  SCORE_W  latest result in ms.
REQ-015 SHALL have port bestScore  output  SCORE_W  minimum valid score since reset.
REQ-016 SHALL have port runCount  output  4  completed runs, saturating at 15.
REQ-017 SHALL have port histSel  input  log2(HIST_DEPTH)  history read index, 0 = newest.
REQ-018 SHALL have port histData  output  SCORE_W  combinational read of the selected history entry.

Function
REQ-019 SHALL generate a one-Clock tick pulse every TICK_DIV cycles, free-running from reset; no derived clocks.
REQ-020 SHALL edge-detect buttonStart and buttonHit; only 0->1 transitions act.
REQ-021 SHALL implement states IDLE=0, DELAY=1, GO=2, RESULT=3, FOUL=4; codes 5-7 SHALL return to IDLE next cycle.
REQ-022 IDLE: start edge -> DELAY; delay target SHALL be 1000 + LFSR[9:0] ticks, captured on the same edge.
REQ-023 SHALL run a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1), seed 16'hACE1, advancing every Clock.
REQ-024 DELAY: on the tick where the delay count equals the target -> GO, score counter cleared.
REQ-025 GO: score SHALL increment once per tick and saturate at all-ones.
REQ-026 GO: first hit edge -> RESULT with winner = lowest index among simultaneous hits, winnerValid=1, score frozen at the value held in that cycle.
REQ-027 GO: score reaching all-ones without a hit -> RESULT, winnerValid=0, score all-ones.
REQ-028 On GO->RESULT, score SHALL be written to history slot 0, older entries shifting by one; the oldest entry is dropped when HIST_DEPTH entries are held.
REQ-029 On GO->RESULT, runCount SHALL increment (saturating); bestScore SHALL update only if winnerValid=1 and score < bestScore.
REQ-030 RESULT/FOUL: start edge -> DELAY (new run); hit edges ignored.
REQ-031 A start edge in DELAY or GO SHALL be ignored.
REQ-032 Unwritten history entries SHALL read all-ones.

Reset
REQ-033 CLRN low SHALL force IDLE, LEDs 0, winner 0, winnerValid 0, score 0, bestScore all-ones, runCount 0, history all-ones, tick divider 0, LFSR to seed, edge detectors 0.
REQ-034 Reset mid-run SHALL abandon the run with no history write.

Configuration
REQ-035 Macro FOUL_LOCKOUT_EN defined: hit edge in DELAY -> FOUL, winner = lowest offending index, winnerValid=1, no history write, runCount unchanged.
REQ-036 FOUL_LOCKOUT_EN undefined: hits in DELAY are ignored; state FOUL is unreachable and RedLed is constant 0.

Verification
REQ-037 TICK_DIV=4: CLRN pulse -> all outputs at REQ-033 values, histData all-ones for every histSel.
REQ-038 Start; hit player 1 at 250 ticks after GreenLed rises -> RESULT, score=250, winner=1, bestScore=250, runCount=1, histData(0)=250.
REQ-039 Players 0 and 1 hit in the same cycle during GO -> winner=0.
REQ-040 SCORE_W=6, no hit -> score=63, winnerValid=0, bestScore unchanged.
REQ-041 With FOUL_LOCKOUT_EN: hit during DELAY -> FOUL, RedLed=1, runCount unchanged; without it: hit ignored, GO still reached.
REQ-042 Run HIST_DEPTH+2 games with scores 10,20,... -> histData(0)=newest score, histData(HIST_DEPTH-1)=score of run 3, runCount saturates at 15 after 15 runs.

Source files
------------

// File: rtl/reaction_game_core.sv
// Reaction-time game core: randomised delay, GO window timing, winner arbitration and history.
// Optional macro FOUL_LOCKOUT_EN turns a hit during the delay into a FOUL ending the run.
`timescale 1ns/1ps
module reaction_game_core #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned SCORE_W     = 13,
  parameter int unsigned HIST_DEPTH  = 8,
  parameter int unsigned TICK_DIV    = 50000
) (
  input  logic                          Clock,
  input  logic                          CLRN,
  input  logic                          buttonStart,
  input  logic [NUM_PLAYERS-1:0]        buttonHit,
  output logic                          GreenLed,
  output logic                          RedLed,
  output logic [2:0]                    state,
  output logic [2:0]                    winner,
  output logic                          winnerValid,
  output logic [SCORE_W-1:0]            score,
  output logic [SCORE_W-1:0]            bestScore,
  output logic [3:0]                    runCount,
  input  logic [$clog2(HIST_DEPTH)-1:0] histSel,
  output logic [SCORE_W-1:0]            histData
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDelay  = 3'd1;
  localparam logic [2:0] StGo     = 3'd2;
  localparam logic [2:0] StResult = 3'd3;
  localparam logic [2:0] StFoul   = 3'd4;

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SCORE_W-1:0] ScoreMax = {SCORE_W{1'b1}};
  localparam logic [15:0] LfsrSeed = 16'hACE1;

  logic [TickW-1:0]       tickCntQ;
  logic                   tick;
  logic [15:0]            lfsrQ;
  logic                   startPrevQ;
  logic [NUM_PLAYERS-1:0] hitPrevQ;
  logic                   startEdge;
  logic [NUM_PLAYERS-1:0] hitEdge;
  logic [2:0]             firstHit;
  logic                   foulHit;

  logic [2:0]             stateQ, stateD;
  logic [10:0]            targetQ, targetD;
  logic [10:0]            delayCntQ, delayCntD;
  logic [10:0]            delayCntInc;
  logic [SCORE_W-1:0]     scoreQ, scoreD;
  logic [SCORE_W-1:0]     scoreInc;
  logic [2:0]             winnerQ, winnerD;
  logic                   validQ, validD;
  logic                   finish;

  logic [SCORE_W-1:0]     bestQ;
  logic [3:0]             runCntQ;
  logic [SCORE_W-1:0]     histQ [HIST_DEPTH];

  // Free-running timebase, LFSR and input edge detectors.
  assign tick = (tickCntQ == TickW'(TICK_DIV - 1));

  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      tickCntQ   <= '0;
      lfsrQ      <= LfsrSeed;
      startPrevQ <= 1'b0;
      hitPrevQ   <= '0;
    end else begin
      tickCntQ   <= tick ? '0 : tickCntQ + 1'b1;
      // Taps 0,2,3,5 of the right-shifting form realise x^16+x^14+x^13+x^11+1.
      lfsrQ      <= {lfsrQ[0] ^ lfsrQ[2] ^ lfsrQ[3] ^ lfsrQ[5], lfsrQ[15:1]};
      startPrevQ <= buttonStart;
      hitPrevQ   <= buttonHit;
    end
  end

  assign startEdge = buttonStart & ~startPrevQ;
  assign hitEdge   = buttonHit & ~hitPrevQ;

  always_comb begin
    firstHit = 3'd0;
    for (int i = int'(NUM_PLAYERS) - 1; i >= 0; i--) begin
      if (hitEdge[i]) firstHit = 3'(i);
    end
  end

`ifdef FOUL_LOCKOUT_EN
  assign foulHit = |hitEdge;
  assign RedLed  = (stateQ == StFoul);
`else
  assign foulHit = 1'b0;
  assign RedLed  = 1'b0;
`endif

  assign delayCntInc = delayCntQ + 11'd1;
  assign scoreInc    = scoreQ + 1'b1;

  always_comb begin
    stateD    = stateQ;
    targetD   = targetQ;
    delayCntD = delayCntQ;
    scoreD    = scoreQ;
    winnerD   = winnerQ;
    validD    = validQ;
    finish    = 1'b0;
    case (stateQ)
      StIdle, StResult, StFoul: begin
        if (startEdge) begin
          stateD    = StDelay;
          targetD   = 11'd1000 + {1'b0, lfsrQ[9:0]};
          delayCntD = '0;
          winnerD   = '0;
          validD    = 1'b0;
        end
      end
      StDelay: begin
        if (foulHit) begin
          stateD  = StFoul;
          winnerD = firstHit;
          validD  = 1'b1;
        end else if (tick) begin
          if (delayCntInc == targetQ) begin
            stateD = StGo;
            scoreD = '0;
          end else begin
            delayCntD = delayCntInc;
          end
        end
      end
      StGo: begin
        // A hit freezes the score even if a tick lands in the same cycle.
        if (|hitEdge) begin
          stateD  = StResult;
          winnerD = firstHit;
          validD  = 1'b1;
          finish  = 1'b1;
        end else if (tick) begin
          scoreD = scoreInc;
          if (scoreInc == ScoreMax) begin
            stateD  = StResult;
            winnerD = '0;
            validD  = 1'b0;
            finish  = 1'b1;
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      stateQ    <= StIdle;
      targetQ   <= '0;
      delayCntQ <= '0;
      scoreQ    <= '0;
      winnerQ   <= '0;
      validQ    <= 1'b0;
    end else begin
      stateQ    <= stateD;
      targetQ   <= targetD;
      delayCntQ <= delayCntD;
      scoreQ    <= scoreD;
      winnerQ   <= winnerD;
      validQ    <= validD;
    end
  end

  // Completed-run bookkeeping: history shift register, run counter, best score.
  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      bestQ   <= ScoreMax;
      runCntQ <= '0;
      for (int i = 0; i < int'(HIST_DEPTH); i++) histQ[i] <= ScoreMax;
    end else if (finish) begin
      histQ[0] <= scoreD;
      for (int i = 1; i < int'(HIST_DEPTH); i++) histQ[i] <= histQ[i-1];
      if (runCntQ != 4'hF) runCntQ <= runCntQ + 4'd1;
      if (validD && (scoreD < bestQ)) bestQ <= scoreD;
    end
  end

  assign GreenLed    = (stateQ == StGo);
  assign state       = stateQ;
  assign winner      = winnerQ;
  assign winnerValid = validQ;
  assign score       = scoreQ;
  assign bestScore   = bestQ;
  assign runCount    = runCntQ;
  assign histData    = histQ[histSel];

endmodule
